// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: dcache/icache arbiter in front of the
// single-port RAM, with per-requester wait/load handshakes.
module mem_arbiter_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ram_err,
  output logic [31:0]       dxfer_cnt,
  output logic [31:0]       ixfer_cnt
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    DGRANT,
    IGRANT
  } state_t;

  state_t      state_q, state_d;
  logic        last_d_q, last_d_d;
  logic        err_q, err_d;
  logic [31:0] dcnt_q, dcnt_d;
  logic [31:0] icnt_q, icnt_d;

  logic dreq;
  logic ram_done;
  logic ram_bad;

  assign dreq     = dREN | dWEN;
  assign ram_bad  = (ramstate == RAM_ERROR);
  assign ram_done = (ramstate == RAM_ACCESS) | ram_bad;

  assign ram_err   = err_q;
  assign dxfer_cnt = dcnt_q;
  assign ixfer_cnt = icnt_q;

  // Grant decode, RAM drive and same-cycle completion handshake.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    err_d    = err_q;
    dcnt_d   = dcnt_q;
    icnt_d   = icnt_q;
    dwait    = 1'b1;
    iwait    = 1'b1;
    dload    = '0;
    iload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      IDLE: begin
        if (dreq && iREN) begin
          state_d = last_d_q ? IGRANT : DGRANT;
        end else if (dreq) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!dreq) begin
          state_d = IDLE;
        end else if (ram_done) begin
          dwait    = 1'b0;
          dload    = dWEN ? '0 : ramload;
          dcnt_d   = dcnt_q + 32'd1;
          last_d_d = 1'b1;
          err_d    = err_q | ram_bad;
          state_d  = IDLE;
        end
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ram_done) begin
          iwait    = 1'b0;
          iload    = ramload;
          icnt_d   = icnt_q + 32'd1;
          last_d_d = 1'b0;
          err_d    = err_q | ram_bad;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, fairness bit, sticky error and transfer counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      err_q    <= 1'b0;
      dcnt_q   <= '0;
      icnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      err_q    <= err_d;
      dcnt_q   <= dcnt_d;
      icnt_q   <= icnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb_mem_arbiter_ctrl: random requesters and RAM model,
// scoreboard queues per requester, directed corner cases.
module tb_mem_arbiter_ctrl;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dREN, dWEN;
  logic [31:0] daddr, dstore, dload;
  logic        dwait;
  logic        iREN;
  logic [31:0] iaddr, iload;
  logic        iwait;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        ram_err;
  logic [31:0] dxfer_cnt, ixfer_cnt;

  mem_arbiter_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .ram_err(ram_err),
    .dxfer_cnt(dxfer_cnt), .ixfer_cnt(ixfer_cnt)
  );

  always #5 CLK = ~CLK;

  int nchk = 0;
  int nerr = 0;

  logic [32:0] d_q[$];
  logic [32:0] i_q[$];
  int          order[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] ram_mem[logic [31:0]];
  logic [31:0] exp_d = 0;
  logic [31:0] exp_i = 0;
  logic        exp_err = 1'b0;

  bit manual = 1'b1;
  bit force_busy = 1'b0;
  bit d_gen = 1'b0;
  bit i_gen = 1'b0;
  int d_prob = 0;
  int i_prob = 0;
  int err_pct = 0;

  logic        m_dren = 1'b0;
  logic        m_dwen = 1'b0;
  logic        m_iren = 1'b0;
  logic [31:0] m_daddr = 0;
  logic [31:0] m_dstore = 0;
  logic [31:0] m_iaddr = 0;

  bit d_busy = 1'b0;
  bit i_busy = 1'b0;
  bit d_done, i_done;

  bit          r_act = 1'b0;
  logic [32:0] r_key;
  int          r_lat;

  function automatic logic [31:0] init_val(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] ram_rd(logic [31:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return init_val(a);
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Addresses with bits [11:8] = 0xE answer with ERROR.
  task automatic issue_d();
    logic [31:0] a, s;
    int k;
    bit e;
    k = $urandom_range(0, 2);
    e = (k == 0) && ($urandom_range(0, 99) < err_pct);
    a = (e ? 32'h0E00 : 32'h0000) + 32'($urandom_range(0, 31));
    s = $urandom;
    if (k == 0) begin
      d_q.push_back({e, ref_rd(a)});
    end else begin
      ref_mem[a] = s;
      d_q.push_back({1'b0, 32'h0});
    end
    dREN = (k != 1);
    dWEN = (k != 0);
    daddr = a;
    dstore = s;
    d_busy = 1'b1;
  endtask

  task automatic issue_i();
    logic [31:0] a;
    bit e;
    e = ($urandom_range(0, 99) < err_pct);
    a = (e ? 32'h1E00 : 32'h1000) + 32'($urandom_range(0, 31));
    i_q.push_back({e, ref_rd(a)});
    iREN = 1'b1;
    iaddr = a;
    i_busy = 1'b1;
  endtask

  task automatic ram_step();
    ramload = $urandom;
    if (!nRST || !(ramREN || ramWEN)) begin
      ramstate = FREE;
      r_act = 1'b0;
    end else begin
      if (!r_act || r_key !== {ramWEN, ramaddr}) begin
        r_act = 1'b1;
        r_key = {ramWEN, ramaddr};
        r_lat = $urandom_range(0, 3);
      end
      if (force_busy) begin
        ramstate = BUSY;
      end else if (r_lat > 0) begin
        ramstate = BUSY;
        r_lat--;
      end else begin
        if (ramWEN) ram_mem[ramaddr] = ramstore;
        ramload = ram_rd(ramaddr);
        ramstate = (ramaddr[11:8] == 4'hE) ? ERROR : ACCESS;
        r_act = 1'b0;
      end
    end
  endtask

  // Requesters and RAM model: drive after each rising edge.
  initial begin : drv
    dREN = 0; dWEN = 0; iREN = 0;
    daddr = 0; dstore = 0; iaddr = 0;
    ramstate = FREE; ramload = 0;
    forever begin
      @(negedge CLK);
      d_done = !dwait;
      i_done = !iwait;
      @(posedge CLK);
      #1;
      if (manual) begin
        dREN = m_dren; dWEN = m_dwen; daddr = m_daddr;
        dstore = m_dstore; iREN = m_iren; iaddr = m_iaddr;
      end else begin
        if (d_busy && d_done) d_busy = 1'b0;
        if (!d_busy) begin
          if (d_gen && $urandom_range(0, 99) < d_prob) issue_d();
          else begin dREN = 0; dWEN = 0; end
        end
        if (i_busy && i_done) i_busy = 1'b0;
        if (!i_busy) begin
          if (i_gen && $urandom_range(0, 99) < i_prob) issue_i();
          else iREN = 0;
        end
      end
      #1;
      ram_step();
    end
  end

  // Monitor: pop and compare on every wait deassertion.
  always @(negedge CLK) begin : mon
    logic [32:0] e;
    if (nRST) begin
      if (!dwait) begin
        chk("d_iwait_excl", iwait, 1);
        chk("d_q_nonempty", d_q.size() != 0, 1);
        if (d_q.size() != 0) begin
          e = d_q.pop_front();
          chk("dload", dload, e[31:0]);
          chk("d_ram_err", ram_err, exp_err);
          chk("dxfer_cnt", dxfer_cnt, exp_d);
          exp_err = exp_err | e[32];
          exp_d = exp_d + 1;
          order.push_back(0);
        end
      end
      if (!iwait) begin
        chk("i_q_nonempty", i_q.size() != 0, 1);
        if (i_q.size() != 0) begin
          e = i_q.pop_front();
          chk("iload", iload, e[31:0]);
          chk("i_ram_err", ram_err, exp_err);
          chk("ixfer_cnt", ixfer_cnt, exp_i);
          exp_err = exp_err | e[32];
          exp_i = exp_i + 1;
          order.push_back(1);
        end
      end
    end
  end

  task automatic wait_drain();
    int t = 0;
    while ((d_busy || i_busy || d_q.size() != 0 ||
            i_q.size() != 0) && t < 500) begin
      @(posedge CLK);
      t++;
    end
    chk("drain_timeout", t < 500, 1);
    repeat (2) @(posedge CLK);
    #3;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_dwait"}, dwait, 1);
    chk({tag, "_iwait"}, iwait, 1);
    chk({tag, "_dload"}, dload, 0);
    chk({tag, "_iload"}, iload, 0);
    chk({tag, "_ramREN"}, ramREN, 0);
    chk({tag, "_ramWEN"}, ramWEN, 0);
    chk({tag, "_ramaddr"}, ramaddr, 0);
    chk({tag, "_ramstore"}, ramstore, 0);
    chk({tag, "_ram_err"}, ram_err, 0);
    chk({tag, "_dxfer"}, dxfer_cnt, 0);
    chk({tag, "_ixfer"}, ixfer_cnt, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int t;
    logic [31:0] dsave;
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    chk_reset_vals("rst");

    // Both requesters always pending: D,I,D,I from reset.
    err_pct = 0; d_prob = 100; i_prob = 100;
    d_gen = 1; i_gen = 1; manual = 0;
    @(negedge CLK);
    nRST = 1'b1;
    t = 0;
    while (order.size() < 4 && t < 400) begin
      @(posedge CLK);
      t++;
    end
    #1;
    chk("alt_timeout", t < 400, 1);
    chk("alt_dxfer", dxfer_cnt, 2);
    chk("alt_ixfer", ixfer_cnt, 2);
    for (int k = 0; k < 4; k++)
      chk("grant_order",
          (k < order.size()) ? order[k] : 9, k % 2);
    #2;
    d_gen = 0; i_gen = 0;
    wait_drain();

    // Random mixed traffic with error-region reads.
    err_pct = 15; d_prob = 60; i_prob = 60;
    d_gen = 1; i_gen = 1;
    repeat (3000) @(posedge CLK);
    #3;
    d_gen = 0; i_gen = 0;
    wait_drain();
    @(negedge CLK);
    chk("rand_dxfer", dxfer_cnt, exp_d);
    chk("rand_ixfer", ixfer_cnt, exp_i);
    chk("rand_ram_err", ram_err, exp_err);

    // Write with REN and WEN both set.
    manual = 1; force_busy = 1;
    ref_mem[32'h3100] = 32'h7;
    d_q.push_back({1'b0, 32'h0});
    m_daddr = 32'h3100; m_dstore = 32'h7;
    m_dren = 1; m_dwen = 1;
    @(posedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    chk("wr_ramWEN", ramWEN, 1);
    chk("wr_ramREN", ramREN, 0);
    chk("wr_ramaddr", ramaddr, 32'h3100);
    chk("wr_ramstore", ramstore, 32'h7);
    chk("wr_dwait_busy", dwait, 1);
    chk("wr_iwait", iwait, 1);
    force_busy = 0;
    t = 0;
    while (dwait && t < 20) begin
      @(negedge CLK);
      t++;
    end
    chk("wr_timeout", t < 20, 1);
    chk("wr_iwait_done", iwait, 1);
    m_dren = 0; m_dwen = 0;
    @(negedge CLK);
    chk("wr_one_pulse", dwait, 1);

    // Request withdrawn while RAM is busy.
    dsave = dxfer_cnt;
    m_daddr = 32'h40; m_dren = 1; force_busy = 1;
    @(negedge CLK);
    @(negedge CLK);
    chk("ab_ramREN", ramREN, 1);
    chk("ab_ramaddr", ramaddr, 32'h40);
    m_dren = 0;
    @(negedge CLK);
    chk("ab_ramREN_drop", ramREN, 0);
    chk("ab_ramWEN_drop", ramWEN, 0);
    chk("ab_dwait", dwait, 1);
    @(negedge CLK);
    chk("ab_dxfer", dxfer_cnt, dsave);
    force_busy = 0;

    // Reset in the middle of a busy dcache grant.
    m_daddr = 32'h44; m_dren = 1; force_busy = 1;
    @(negedge CLK);
    @(negedge CLK);
    chk("mr_ramREN", ramREN, 1);
    nRST = 1'b0;
    #1;
    chk_reset_vals("mr");
    m_dren = 0;
    exp_d = 0; exp_i = 0; exp_err = 1'b0;
    d_q.delete(); i_q.delete();
    force_busy = 0;
    @(negedge CLK);
    nRST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_dxfer", dxfer_cnt, 0);
    chk("post_ixfer", ixfer_cnt, 0);
    chk("post_ramREN", ramREN, 0);

    // One icache read to show the arbiter restarts cleanly.
    m_iaddr = 32'h1004;
    i_q.push_back({1'b0, ref_rd(32'h1004)});
    m_iren = 1;
    t = 0;
    @(negedge CLK);
    while (iwait && t < 20) begin
      @(negedge CLK);
      t++;
    end
    chk("post_i_timeout", t < 20, 1);
    m_iren = 0;
    @(negedge CLK);
    chk("post_ixfer1", ixfer_cnt, 1);
    chk("post_iq_empty", i_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Memory-side responder for the cache control interface.
- Accepts word requests from one dcache (read/write) and one icache (read only), arbitrates between them, and drives the single-port RAM.
- Returns per-requester wait/load handshakes: wait held high until the RAM reports the access complete.
- Sits between the caches and the RAM model; dcache traffic includes block fills, write-backs and the halt-time flush/hit-count store.

Parameters:
- ADDR_W, 32, address width of daddr/iaddr/ramaddr.
- DATA_W, 32, word width of all data buses.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache word address
- dstore  in  DATA_W  dcache write data
- dwait  out  1  high = dcache request not complete
- dload  out  DATA_W  dcache read data, valid when dwait=0
- iREN  in  1  icache read request
- iaddr  in  ADDR_W  icache word address
- iwait  out  1  high = icache request not complete
- iload  out  DATA_W  icache read data, valid when iwait=0
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- ram_err  out  1  sticky, set on any ERROR completion
- dxfer_cnt  out  32  completed dcache transfers
- ixfer_cnt  out  32  completed icache transfers

Behaviour:
Reset:
- State IDLE, last_grant=I.
- dwait=iwait=1; dload=iload=0.
- ramREN=ramWEN=0; ramaddr=ramstore=0.
- ram_err=0; both counters 0.
- Reset mid-transfer aborts immediately, with no completion pulse and no counter increment.

FSM states: IDLE, DGRANT, IGRANT (registered).

IDLE:
- RAM enables 0; both waits 1.
- dreq = dREN|dWEN.
- If dreq and iREN: go to DGRANT if last_grant=I, else IGRANT.
- Else dreq -> DGRANT; else iREN -> IGRANT; else stay.

DGRANT:
- ramaddr=daddr and ramstore=dstore, both combinational so they track live inputs.
- If dWEN: ramWEN=1, ramREN=0 (write wins if both set). Else ramREN=dREN.
- iwait=1.
- Completion = ramstate is ACCESS or ERROR while granted request still asserted. On completion, that same cycle:
  - dwait=0, dload=ramload (0 on a write).
  - dxfer_cnt+1, last_grant<=D; ERROR also sets ram_err.
  - Next state IDLE.
- If dREN and dWEN both drop before completion: RAM enables 0 that cycle, next IDLE, no count.

IGRANT:
- ramREN=1, ramaddr=iaddr, ramWEN=0.
- Completion rule as for DGRANT, using iwait/iload/ixfer_cnt and last_grant<=I.
- dwait=1 throughout.

Timing and handshake rules:
- Minimum latency: request seen in cycle N (IDLE), grant in N+1. If ramstate=ACCESS in N+1, wait drops in N+1. Each word therefore costs ≥2 cycles.
- Exactly one wait deasserts per completion, and only for one cycle; the requester must change address or drop its request before the next IDLE.
- Both requesters pending continuously gives strict alternation D,I,D,I. A dcache two-word fill or write-back may be split by one icache word; the dcache simply keeps waiting.
- BUSY and FREE: hold state, keep RAM signals driven.
- Counters wrap 0xFFFFFFFF -> 0.
- ram_err clears only on reset.

Test Plan:
1. dREN=1, daddr=0x40, RAM returns 0xDEADBEEF with ACCESS after 3 BUSY cycles -> dwait low exactly one cycle with dload=0xDEADBEEF; ramREN high 4 cycles; dxfer_cnt=1.
2. dWEN=1 and dREN=1, daddr=0x3100, dstore=0x7 -> ramWEN=1, ramREN=0, ramaddr=0x3100, ramstore=0x7; completion pulses dwait only.
3. iREN and dREN held continuously for 4 completions, from reset -> grant order D,I,D,I; dxfer_cnt=2, ixfer_cnt=2; iwait and dwait never low in the same cycle.
4. iREN=1 and ramstate=ERROR at the grant -> iwait low one cycle; ram_err=1 and remains 1 across later successful transfers.
5. Assert nRST low while in DGRANT with ramstate=BUSY -> outputs return to reset values immediately; after release, state IDLE and counters 0.
6. dREN deasserted while in DGRANT with ramstate=BUSY -> ramREN=0 that cycle, next state IDLE, dxfer_cnt unchanged.
